// File: rtl/hamming_enc_seq.sv
// Sequential Hamming(15,11) encode engine: reads NUM_MSG two-byte messages from data memory,
// drives them through an external combinational encoder and writes the two-byte codewords back.
module hamming_enc_seq #(
    parameter int unsigned NUM_MSG  = 30,
    parameter int unsigned IN_BASE  = 0,
    parameter int unsigned OUT_BASE = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        done_o,
    output logic        busy_o,
    output logic [7:0]  mem_addr_o,
    output logic        mem_wr_en_o,
    output logic [7:0]  mem_wr_data_o,
    input  logic [7:0]  mem_rd_data_i,
    output logic [10:0] enc_din_o,
    input  logic [14:0] enc_dout_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StLatch,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    localparam logic [5:0] LastIdx = 6'(NUM_MSG - 1);
    localparam logic [7:0] InBase  = 8'(IN_BASE);
    localparam logic [7:0] OutBase = 8'(OUT_BASE);

    state_e     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [7:0] lo_q, lo_d;
    logic [2:0] hi_q, hi_d;

    logic [7:0] idx_x2;
    logic [7:0] in_addr;
    logic [7:0] out_addr;

    // Byte offset of message idx; addresses wrap modulo 256.
    assign idx_x2   = {1'b0, idx_q, 1'b0};
    assign in_addr  = InBase + idx_x2;
    assign out_addr = OutBase + idx_x2;

    assign enc_din_o = {hi_q, lo_q};
    assign done_o    = (state_q == StDone);
    assign busy_o    = (state_q != StIdle) && (state_q != StDone);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        mem_addr_o    = 8'h00;
        mem_wr_en_o   = 1'b0;
        mem_wr_data_o = 8'h00;

        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StRdLo;
                    idx_d   = 6'd0;
                end
            end
            StRdLo: begin
                mem_addr_o = in_addr;
                state_d    = StRdHi;
            end
            StRdHi: begin
                mem_addr_o = in_addr + 8'd1;
                lo_d       = mem_rd_data_i;
                state_d    = StLatch;
            end
            StLatch: begin
                hi_d    = mem_rd_data_i[2:0];
                state_d = StWrLo;
            end
            StWrLo: begin
                mem_addr_o    = out_addr;
                mem_wr_en_o   = 1'b1;
                mem_wr_data_o = enc_dout_i[7:0];
                state_d       = StWrHi;
            end
            StWrHi: begin
                mem_addr_o    = out_addr + 8'd1;
                mem_wr_en_o   = 1'b1;
                mem_wr_data_o = {1'b0, enc_dout_i[14:8]};
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = StRdLo;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            idx_q   <= 6'd0;
            lo_q    <= 8'h00;
            hi_q    <= 3'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Bench for hamming_enc_seq: memory model, behavioural encoder and a write scoreboard.
module tb_hamming_enc_seq;

    localparam int NumMsg = 30;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        done_o;
    logic        busy_o;
    logic [7:0]  mem_addr_o;
    logic        mem_wr_en_o;
    logic [7:0]  mem_wr_data_o;
    logic [7:0]  mem_rd_data_i;
    logic [10:0] enc_din_o;
    logic [14:0] enc_dout_i;

    logic [7:0] mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data = 8'h00;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    hamming_enc_seq #(
        .NUM_MSG (NumMsg),
        .IN_BASE (0),
        .OUT_BASE(64)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wr_en_o  (mem_wr_en_o),
        .mem_wr_data_o(mem_wr_data_o),
        .mem_rd_data_i(mem_rd_data_i),
        .enc_din_o    (enc_din_o),
        .enc_dout_i   (enc_dout_i)
    );

    // Bit i of the codeword is Hamming position i+1; parity at 1,2,4,8.
    function automatic logic [14:0] ham(input logic [10:0] d);
        logic [14:0] c;
        int          j;
        logic        par;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= 15; pos++) begin
            if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 15; pos++) begin
                if (((pos & p) != 0) && pos != p) par = par ^ c[pos-1];
            end
            c[p-1] = par;
        end
        return c;
    endfunction

    assign enc_dout_i = ham(enc_din_o);

    always @(posedge clk) begin
        mem_rd_data_i <= mem[mem_addr_o];
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wr_en_o) mem[mem_addr_o] <= mem_wr_data_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    // Inputs: two directed messages then random; outputs pre-filled with a sentinel.
    task automatic load_mem();
        poke(8'd0, 8'hFF);
        poke(8'd1, 8'h07);
        poke(8'd2, 8'h01);
        poke(8'd3, 8'hF8);
        for (int i = 4; i < 2 * NumMsg; i++) poke(8'(i), 8'($urandom_range(0, 255)));
        for (int i = 64; i < 128; i++) poke(8'(i), 8'hA5);
    endtask

    // Pushes the expected write sequence, then presents start for one edge.
    task automatic launch();
        logic [14:0] c;
        exp_q.delete();
        for (int k = 0; k < NumMsg; k++) begin
            c = ham({mem[2*k+1][2:0], mem[2*k]});
            exp_q.push_back({8'(64 + 2 * k), c[7:0]});
            exp_q.push_back({8'(65 + 2 * k), {1'b0, c[14:8]}});
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({done_o, busy_o, mem_wr_en_o, mem_addr_o, mem_wr_data_o, enc_din_o} !== '0) begin
            $display("FAIL reset_outputs: got done=%b busy=%b we=%b addr=%h wd=%h din=%h want all 0",
                     done_o, busy_o, mem_wr_en_o, mem_addr_o, mem_wr_data_o, enc_din_o);
        end else pass_cnt++;
        reset_i = 1'b0;
        tick();
        total_cnt++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            $display("FAIL idle_hold: got busy=%b done=%b want 0 0", busy_o, done_o);
        end else pass_cnt++;
    endtask

    task automatic test_full_run();
        int   cyc;
        bit   got_done;
        wr_t  e;
        load_mem();
        launch();
        cyc = 1;
        got_done = 0;
        while (!got_done && cyc < 400) begin
            if (mem_wr_en_o) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL run_extra_write: addr=%h data=%h, none expected",
                             mem_addr_o, mem_wr_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr_o !== e.a || mem_wr_data_o !== e.d)
                        $display("FAIL run_write: got %h:%h want %h:%h",
                                 mem_addr_o, mem_wr_data_o, e.a, e.d);
                    else pass_cnt++;
                end
            end
            if (done_o) begin
                got_done = 1;
                total_cnt++;
                if (cyc !== 151) $display("FAIL run_latency: got %0d want 151", cyc);
                else pass_cnt++;
            end else begin
                tick();
                cyc++;
            end
        end
        total_cnt++;
        if (!got_done || exp_q.size() != 0)
            $display("FAIL run_complete: done=%b left=%0d want 1 0", got_done, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if ({mem[64], mem[65], mem[66], mem[67]} !== 32'hFF7F_0700)
            $display("FAIL directed_bytes: got %h%h%h%h want ff7f0700",
                     mem[64], mem[65], mem[66], mem[67]);
        else pass_cnt++;
        total_cnt++;
        if (mem[124] !== 8'hA5 || mem[63] === 8'hA5 && NumMsg > 31)
            $display("FAIL out_of_range_write: mem[124]=%h want a5", mem[124]);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy();
        int   cyc;
        bit   got_done;
        wr_t  e;
        launch();
        cyc = 1;
        got_done = 0;
        while (!got_done && cyc < 400) begin
            start_i = (cyc == 40);
            if (mem_wr_en_o) begin
                total_cnt++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (mem_addr_o !== e.a || mem_wr_data_o !== e.d)
                    $display("FAIL busy_write: got %h:%h want %h:%h",
                             mem_addr_o, mem_wr_data_o, e.a, e.d);
                else pass_cnt++;
            end
            if (done_o) begin
                got_done = 1;
                total_cnt++;
                if (cyc !== 151) $display("FAIL busy_latency: got %0d want 151", cyc);
                else pass_cnt++;
            end else begin
                tick();
                cyc++;
            end
        end
        start_i = 1'b0;
        total_cnt++;
        if (!got_done || exp_q.size() != 0)
            $display("FAIL busy_complete: done=%b left=%0d want 1 0", got_done, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_done_restart();
        int   cyc;
        bit   got_done;
        wr_t  e;
        tick();
        tick();
        total_cnt++;
        if (done_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL done_hold: got done=%b busy=%b want 1 0", done_o, busy_o);
        else pass_cnt++;
        launch();
        total_cnt++;
        if (done_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL restart_flags: got done=%b busy=%b want 0 1", done_o, busy_o);
        else pass_cnt++;
        cyc = 1;
        got_done = 0;
        while (!got_done && cyc < 400) begin
            if (mem_wr_en_o) begin
                total_cnt++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (mem_addr_o !== e.a || mem_wr_data_o !== e.d)
                    $display("FAIL restart_write: got %h:%h want %h:%h",
                             mem_addr_o, mem_wr_data_o, e.a, e.d);
                else pass_cnt++;
            end
            if (done_o) begin
                got_done = 1;
                total_cnt++;
                if (cyc !== 151) $display("FAIL restart_latency: got %0d want 151", cyc);
                else pass_cnt++;
            end else begin
                tick();
                cyc++;
            end
        end
        total_cnt++;
        if (!got_done) $display("FAIL restart_timeout: done never rose");
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int   cyc;
        int   bad;
        wr_t  e;
        load_mem();
        launch();
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (mem_wr_en_o) begin
                total_cnt++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (mem_addr_o !== e.a || mem_wr_data_o !== e.d)
                    $display("FAIL abort_write: got %h:%h want %h:%h",
                             mem_addr_o, mem_wr_data_o, e.a, e.d);
                else pass_cnt++;
            end
            if (cyc < 20) tick();
        end
        // Now in WR_HI of message 3; reset and start together, reset must win.
        total_cnt++;
        if (mem_addr_o !== 8'd71) $display("FAIL abort_point: addr=%h want 47", mem_addr_o);
        else pass_cnt++;
        reset_i = 1'b1;
        start_i = 1'b1;
        tick();
        reset_i = 1'b0;
        start_i = 1'b0;
        total_cnt++;
        if ({busy_o, done_o, mem_wr_en_o, mem_addr_o} !== '0)
            $display("FAIL abort_state: got busy=%b done=%b we=%b addr=%h want 0",
                     busy_o, done_o, mem_wr_en_o, mem_addr_o);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) tick();
        bad = 0;
        for (int i = 72; i < 128; i++) if (mem[i] !== 8'hA5) bad++;
        total_cnt++;
        if (bad != 0 || busy_o !== 1'b0)
            $display("FAIL abort_untouched: %0d bytes changed busy=%b want 0 0", bad, busy_o);
        else pass_cnt++;
        test_full_run_again();
    endtask

    task automatic test_full_run_again();
        int   cyc;
        bit   got_done;
        wr_t  e;
        launch();
        cyc = 1;
        got_done = 0;
        while (!got_done && cyc < 400) begin
            if (mem_wr_en_o) begin
                total_cnt++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (mem_addr_o !== e.a || mem_wr_data_o !== e.d)
                    $display("FAIL rerun_write: got %h:%h want %h:%h",
                             mem_addr_o, mem_wr_data_o, e.a, e.d);
                else pass_cnt++;
            end
            if (done_o) got_done = 1;
            else begin
                tick();
                cyc++;
            end
        end
        total_cnt++;
        if (!got_done || cyc !== 151 || exp_q.size() != 0)
            $display("FAIL rerun_complete: done=%b cyc=%0d left=%0d want 1 151 0",
                     got_done, cyc, exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_start_while_busy();
        test_done_restart();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
